// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low patterns, bit order {a,b,c,d,e,f,g,dp}.
// Imported by the scan driver and by the status monitor's display logic.
package seg_pkg;

  localparam int NDIG = 8;

  typedef logic [7:0] seg_pat_t;

  localparam seg_pat_t SEGNONE = 8'hFF;

  localparam seg_pat_t SEG_HEX_0 = 8'h03;
  localparam seg_pat_t SEG_HEX_1 = 8'h9F;
  localparam seg_pat_t SEG_HEX_2 = 8'h25;
  localparam seg_pat_t SEG_HEX_3 = 8'h0D;
  localparam seg_pat_t SEG_HEX_4 = 8'h99;
  localparam seg_pat_t SEG_HEX_5 = 8'h49;
  localparam seg_pat_t SEG_HEX_6 = 8'h41;
  localparam seg_pat_t SEG_HEX_7 = 8'h1F;
  localparam seg_pat_t SEG_HEX_8 = 8'h01;
  localparam seg_pat_t SEG_HEX_9 = 8'h09;
  localparam seg_pat_t SEG_HEX_A = 8'h11;
  localparam seg_pat_t SEG_HEX_B = 8'hC1;
  localparam seg_pat_t SEG_HEX_C = 8'h63;
  localparam seg_pat_t SEG_HEX_D = 8'h85;
  localparam seg_pat_t SEG_HEX_E = 8'h61;
  localparam seg_pat_t SEG_HEX_F = 8'h71;

  // Output phase of the current slot; OFF covers the disabled display.
  typedef enum logic [1:0] {
    PH_OFF   = 2'd0,
    PH_BLANK = 2'd1,
    PH_SHOW  = 2'd2
  } slot_phase_t;

  function automatic seg_pat_t hex_to_seg(input logic [3:0] nib);
    seg_pat_t pat;
    case (nib)
      4'h0: pat = SEG_HEX_0;
      4'h1: pat = SEG_HEX_1;
      4'h2: pat = SEG_HEX_2;
      4'h3: pat = SEG_HEX_3;
      4'h4: pat = SEG_HEX_4;
      4'h5: pat = SEG_HEX_5;
      4'h6: pat = SEG_HEX_6;
      4'h7: pat = SEG_HEX_7;
      4'h8: pat = SEG_HEX_8;
      4'h9: pat = SEG_HEX_9;
      4'hA: pat = SEG_HEX_A;
      4'hB: pat = SEG_HEX_B;
      4'hC: pat = SEG_HEX_C;
      4'hD: pat = SEG_HEX_D;
      4'hE: pat = SEG_HEX_E;
      default: pat = SEG_HEX_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_slot_counter.sv
// Slot timing for the scan driver: tick within a slot and the digit being scanned.
// Both counters hold at zero while disabled so a re-enable restarts at digit 0, blank phase.
module seg_slot_counter
  import seg_pkg::*;
#(
  parameter int DIV   = 1000,
  parameter int BLANK = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  output logic [2:0] digit_o,
  output logic       slot_end_o,
  output logic       frame_end_o,
  output logic       in_blank_o
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX   = TW'(DIV - 1);
  localparam logic [TW-1:0] TICK_BLANK = TW'(BLANK);

  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    digit_q, digit_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_q  <= '0;
      digit_q <= '0;
    end else begin
      tick_q  <= tick_d;
      digit_q <= digit_d;
    end
  end

  always_comb begin
    tick_d  = tick_q;
    digit_d = digit_q;
    if (!enable_i) begin
      tick_d  = '0;
      digit_d = '0;
    end else if (tick_q == TICK_MAX) begin
      tick_d  = '0;
      digit_d = digit_q + 3'd1;
    end else begin
      tick_d = tick_q + TW'(1);
    end
  end

  assign digit_o     = digit_q;
  assign slot_end_o  = enable_i && (tick_q == TICK_MAX);
  assign frame_end_o = slot_end_o && (digit_q == 3'd7);
  assign in_blank_o  = (tick_q < TICK_BLANK);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit seven-segment scan driver with double-buffered patterns.
// Shadow loads commit to the displayed set only at a frame boundary or while disabled.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIV   = 1000,
  parameter int BLANK = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       load_i,
  input  logic [7:0] seg0_i,
  input  logic [7:0] seg1_i,
  input  logic [7:0] seg2_i,
  input  logic [7:0] seg3_i,
  input  logic [7:0] seg4_i,
  input  logic [7:0] seg5_i,
  input  logic [7:0] seg6_i,
  input  logic [7:0] seg7_i,
  output logic [7:0] seg_o,
  output logic [7:0] an_o,
  output logic       frame_o
);

  seg_pat_t    seg_in [NDIG];
  seg_pat_t    shadow_q [NDIG];
  seg_pat_t    shadow_d [NDIG];
  seg_pat_t    active_q [NDIG];
  seg_pat_t    active_d [NDIG];
  logic        pending_q, pending_d;
  seg_pat_t    seg_q, seg_d;
  logic [7:0]  an_q, an_d;
  logic        frame_q, frame_d;
  logic [2:0]  digit;
  logic        slot_end;
  logic        frame_end;
  logic        in_blank;
  slot_phase_t phase;

  assign seg_in[0] = seg0_i;
  assign seg_in[1] = seg1_i;
  assign seg_in[2] = seg2_i;
  assign seg_in[3] = seg3_i;
  assign seg_in[4] = seg4_i;
  assign seg_in[5] = seg5_i;
  assign seg_in[6] = seg6_i;
  assign seg_in[7] = seg7_i;

  seg_slot_counter #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) u_slot_counter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .digit_o     (digit),
    .slot_end_o  (slot_end),
    .frame_end_o (frame_end),
    .in_blank_o  (in_blank)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NDIG; k++) begin
        shadow_q[k] <= SEGNONE;
        active_q[k] <= SEGNONE;
      end
      pending_q <= 1'b0;
      seg_q     <= SEGNONE;
      an_q      <= 8'hFF;
      frame_q   <= 1'b0;
    end else begin
      for (int k = 0; k < NDIG; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
      end
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      frame_q   <= frame_d;
    end
  end

  // Commit uses the pre-load shadow; a load in the same cycle stays pending.
  always_comb begin
    for (int k = 0; k < NDIG; k++) begin
      shadow_d[k] = shadow_q[k];
      active_d[k] = active_q[k];
    end
    pending_d = pending_q;
    if (pending_q && (!enable_i || frame_end)) begin
      for (int k = 0; k < NDIG; k++) begin
        active_d[k] = shadow_q[k];
      end
      pending_d = 1'b0;
    end
    if (load_i) begin
      for (int k = 0; k < NDIG; k++) begin
        shadow_d[k] = seg_in[k];
      end
      pending_d = 1'b1;
    end
  end

  always_comb begin
    phase = PH_OFF;
    if (enable_i) begin
      phase = in_blank ? PH_BLANK : PH_SHOW;
    end
  end

  always_comb begin
    seg_d   = SEGNONE;
    an_d    = 8'hFF;
    frame_d = frame_end;
    case (phase)
      PH_SHOW: begin
        seg_d = active_q[digit];
        an_d  = ~(8'h01 << digit);
      end
      default: begin
        seg_d = SEGNONE;
        an_d  = 8'hFF;
      end
    endcase
  end

  assign seg_o   = seg_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;

  logic unused_slot_end;
  assign unused_slot_end = slot_end;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: per-edge expectations from a position-based model, checked by a monitor.
module tb_seg_scan_driver;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = 8 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       load;
  logic [7:0] seg_in [8];
  logic [7:0] seg;
  logic [7:0] an;
  logic       frame;

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] exp_q[$];

  // Reference model: scan position in cycles since enable, plus the two buffers.
  logic [7:0] m_shadow [8];
  logic [7:0] m_active [8];
  bit         m_pending;
  int         m_pos;

  logic [7:0] e_seg, e_an;
  logic       e_frame;
  bit         m_boundary;
  int         m_t, m_d;
  logic [7:0] one8 = 8'h01;

  seg_scan_driver #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .enable_i (enable),
    .load_i   (load),
    .seg0_i   (seg_in[0]),
    .seg1_i   (seg_in[1]),
    .seg2_i   (seg_in[2]),
    .seg3_i   (seg_in[3]),
    .seg4_i   (seg_in[4]),
    .seg5_i   (seg_in[5]),
    .seg6_i   (seg_in[6]),
    .seg7_i   (seg_in[7]),
    .seg_o    (seg),
    .an_o     (an),
    .frame_o  (frame)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_shadow[k] = 8'hFF;
      m_active[k] = 8'hFF;
    end
    m_pending = 1'b0;
    m_pos     = 0;
  endtask

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got seg=%h an=%h frame=%b, expected seg=%h an=%h frame=%b",
               name, $time, act[16:9], act[8:1], act[0], exp[16:9], exp[8:1], exp[0]);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s @%0t: timed out waiting for scan position", name, $time);
  endtask

  // Model step: expectation reflects state before the edge, then state advances.
  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      e_seg = 8'hFF;
      e_an = 8'hFF;
      e_frame = 1'b0;
      m_boundary = 1'b0;
      if (enable) begin
        m_t = m_pos % DIV;
        m_d = (m_pos / DIV) % 8;
        if (m_t >= BLANK) begin
          e_seg = m_active[m_d];
          e_an  = ~(one8 << m_d);
        end
        m_boundary = ((m_pos % FRAME) == FRAME - 1);
        e_frame = m_boundary;
      end
      exp_q.push_back({e_seg, e_an, e_frame});
      if (m_pending && (!enable || m_boundary)) begin
        for (int k = 0; k < 8; k++) m_active[k] = m_shadow[k];
        m_pending = 1'b0;
      end
      m_pos = enable ? (m_pos + 1) % FRAME : 0;
      if (load) begin
        for (int k = 0; k < 8; k++) m_shadow[k] = seg_in[k];
        m_pending = 1'b1;
      end
    end
  end

  // Monitor: the outputs visible at a falling edge belong to the previous rising edge.
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      logic [16:0] e;
      e = exp_q.pop_front();
      check("scan", {seg, an, frame}, e);
      n_checks++;
      if ($countones(~an) > 1) begin
        n_fail++;
        $display("FAIL an_onehot @%0t: got an=%h, expected at most one low bit", $time, an);
      end
    end
  end

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) next();
  endtask

  task automatic do_load(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [7:0] d3, input logic [7:0] d4, input logic [7:0] d5,
                         input logic [7:0] d6, input logic [7:0] d7);
    seg_in[0] = d0; seg_in[1] = d1; seg_in[2] = d2; seg_in[3] = d3;
    seg_in[4] = d4; seg_in[5] = d5; seg_in[6] = d6; seg_in[7] = d7;
    load = 1'b1;
    next();
    load = 1'b0;
  endtask

  task automatic load_random();
    do_load(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  // Waits until the next rising edge will sample the counters at (digit, tick).
  task automatic wait_pos(input int digit, input int tick, input string name);
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (enable && (m_pos == digit * DIV + tick)) return;
      next();
    end
    fail_timeout(name);
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    load = 1'b0;
    for (int k = 0; k < 8; k++) seg_in[k] = 8'hFF;
    model_reset();
    #12;
    check("reset_outputs", {seg, an, frame}, {8'hFF, 8'hFF, 1'b0});
    next();
    rst = 1'b0;

    // Cold start while disabled, then enable.
    run(2);
    do_load(8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    run(2);
    enable = 1'b1;
    run(3 * FRAME);

    // Mid-frame load while digit 5 is on.
    wait_pos(5, 2, "wait_digit5");
    do_load(8'h03, 8'h9F, 8'h25, 8'h9F, 8'h99, 8'h49, 8'h41, 8'h1F);
    run(2 * FRAME);

    // Load on the internal boundary edge, and again on the cycle frame_o is high.
    wait_pos(7, DIV - 1, "wait_boundary");
    load_random();
    run(2 * FRAME + 3);
    wait_pos(0, 0, "wait_frame_high");
    load_random();
    run(2 * FRAME);

    // Disable during digit 4, load while off, then re-enable.
    wait_pos(4, 2, "wait_digit4");
    enable = 1'b0;
    run(3);
    load_random();
    run(3);
    enable = 1'b1;
    run(FRAME + 5);

    // Random enable toggling and loads.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      if ($urandom_range(0, 11) == 0) load_random();
      else next();
    end
    enable = 1'b1;
    load_random();
    run(2 * FRAME);

    // Asynchronous reset between edges during a SHOW cycle.
    wait_pos(2, 2, "wait_digit2");
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    model_reset();
    #1;
    check("async_reset", {seg, an, frame}, {8'hFF, 8'hFF, 1'b0});
    next();
    rst = 1'b0;
    run(FRAME + 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
